// File: rtl/uart_fifo.sv
// uart_fifo: MMIO UART with TX/RX FIFOs, runtime baud divisor, optional parity and a level irq.
// Register index in a; byte payload lives in d[31:24] / spo[31:24].
module uart_fifo #(
    parameter int unsigned CLOCK_FREQ = 62500000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        re,
    output logic [31:0] spo,
    output logic        irq,
    input  logic        rx,
    output logic        tx
);
    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam int unsigned TxCw = TxAw + 1;
    localparam int unsigned RxCw = RxAw + 1;
    localparam logic [15:0] DivReset = 16'(CLOCK_FREQ / (BAUD_RATE * 16) - 1);
    localparam logic [2:0]  BitLast  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [4:0]  ctrl_q;
    logic [15:0] div_q, cnt_q;
    logic [3:0]  err_q, err_d, err_set;
    logic        irq_q, irq_d, os_tick;
    logic        wr_data, wr_stat, wr_ctrl, wr_div, par_en, par_odd;

    assign wr_data = we && (a == 3'd0);
    assign wr_stat = we && (a == 3'd1);
    assign wr_ctrl = we && (a == 3'd2);
    assign wr_div  = we && (a == 3'd3);
    assign par_en  = ctrl_q[0] ^ ctrl_q[1];
    assign par_odd = ctrl_q[1];
    assign os_tick = (cnt_q == div_q);
    assign irq     = irq_q;

    // TX FIFO and FSM
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TxAw-1:0]      tx_wp_q, tx_rp_q;
    logic [TxCw-1:0]      tx_cnt_q;
    logic                 tx_full, tx_push, tx_pop, tx_idle, tx_bit_end;
    state_e               tx_st_q, tx_st_d;
    logic [3:0]           tx_os_q;
    logic [2:0]           tx_bit_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic                 tx_par_q;

    assign tx_full    = (tx_cnt_q == TxCw'(TX_DEPTH));
    assign tx_push    = wr_data && !tx_full;
    assign tx_idle    = (tx_st_q == StIdle) && (tx_cnt_q == '0);
    assign tx_bit_end = os_tick && (tx_os_q == 4'd15);

    // RX synchroniser, FIFO and FSM
    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RxAw-1:0]      rx_wp_q, rx_rp_q;
    logic [RxCw-1:0]      rx_cnt_q;
    logic                 rx_s1_q, rx_s2_q, rx_full, rx_push, rx_pop, rx_wr, rx_mid, rx_end;
    state_e               rx_st_q, rx_st_d;
    logic [3:0]           rx_os_q;
    logic [2:0]           rx_bit_q;
    logic [DATA_BITS-1:0] rx_sh_q;
    logic                 rx_pbad_q;

    assign rx_full = (rx_cnt_q == RxCw'(RX_DEPTH));
    assign rx_pop  = re && (a == 3'd0) && (rx_cnt_q != '0);
    assign rx_mid  = os_tick && (rx_os_q == 4'd8);
    assign rx_end  = os_tick && (rx_os_q == 4'd15);
    assign rx_push = (rx_st_q == StStop) && rx_mid;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign rx_wr   = rx_push && (!rx_full || rx_pop);

    assign err_set = {wr_data && tx_full, rx_push && !rx_s2_q, rx_push && rx_pbad_q,
                      rx_push && rx_full && !rx_pop};

    always_comb begin
        // Hardware set wins over a coincident write-one-to-clear.
        err_d = (err_q & ~(wr_stat ? d[31:28] : 4'b0)) | err_set;
        irq_d = (ctrl_q[2] && (rx_cnt_q != '0)) || (ctrl_q[3] && tx_idle) ||
                (ctrl_q[4] && (err_q != '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            div_q  <= DivReset;
            cnt_q  <= '0;
            err_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_q <= d[28:24];
            if (wr_div) begin
                div_q <= d[15:0];
                cnt_q <= '0;
            end else if (os_tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
            err_q <= err_d;
            irq_q <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= d[24 +: DATA_BITS];
        if (rx_wr)   rx_mem[rx_wp_q] <= rx_sh_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + TxAw'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + TxAw'(1);
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + TxCw'(1);
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - TxCw'(1);
            if (rx_wr)  rx_wp_q <= rx_wp_q + RxAw'(1);
            if (rx_pop) rx_rp_q <= rx_rp_q + RxAw'(1);
            if (rx_wr && !rx_pop)      rx_cnt_q <= rx_cnt_q + RxCw'(1);
            else if (!rx_wr && rx_pop) rx_cnt_q <= rx_cnt_q - RxCw'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q  <= StIdle;
            rx_st_q  <= StIdle;
        end else begin
            tx_st_q  <= tx_st_d;
            rx_st_q  <= rx_st_d;
        end
    end

    always_comb begin
        tx_st_d = tx_st_q;
        tx_pop  = 1'b0;
        unique case (tx_st_q)
            StIdle:   if (tx_cnt_q != '0) begin
                          tx_pop  = 1'b1;
                          tx_st_d = StStart;
                      end
            StStart:  if (tx_bit_end) tx_st_d = StData;
            StData:   if (tx_bit_end && tx_bit_q == BitLast) tx_st_d = par_en ? StParity : StStop;
            StParity: if (tx_bit_end) tx_st_d = StStop;
            StStop:   if (tx_bit_end) begin
                          tx_pop  = (tx_cnt_q != '0);
                          tx_st_d = tx_pop ? StStart : StIdle;
                      end
            default:  tx_st_d = StIdle;
        endcase
    end

    always_comb begin
        unique case (tx_st_q)
            StStart:  tx = 1'b0;
            StData:   tx = tx_sh_q[0];
            StParity: tx = tx_par_q;
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_os_q  <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
        end else if (tx_pop) begin
            tx_os_q  <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= tx_mem[tx_rp_q];
            tx_par_q <= (^tx_mem[tx_rp_q]) ^ par_odd;
        end else if (os_tick) begin
            tx_os_q <= tx_os_q + 4'd1;
            if (tx_bit_end && tx_st_q == StData) begin
                tx_sh_q  <= tx_sh_q >> 1;
                tx_bit_q <= tx_bit_q + 3'd1;
            end
        end
    end

    always_comb begin
        rx_st_d = rx_st_q;
        unique case (rx_st_q)
            StIdle:   if (!rx_s2_q) rx_st_d = StStart;
            StStart:  if (rx_mid && rx_s2_q) rx_st_d = StIdle;
                      else if (rx_end) rx_st_d = StData;
            StData:   if (rx_end && rx_bit_q == BitLast) rx_st_d = par_en ? StParity : StStop;
            StParity: if (rx_end) rx_st_d = StStop;
            StStop:   if (rx_mid) rx_st_d = StIdle;
            default:  rx_st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_os_q   <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_pbad_q <= 1'b0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            if (rx_st_q == StIdle) begin
                rx_os_q   <= '0;
                rx_bit_q  <= '0;
                rx_pbad_q <= 1'b0;
            end else if (os_tick) begin
                rx_os_q <= rx_os_q + 4'd1;
                if (rx_st_q == StData && rx_mid) rx_sh_q <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                if (rx_st_q == StData && rx_end) rx_bit_q <= rx_bit_q + 3'd1;
                if (rx_st_q == StParity && rx_mid) rx_pbad_q <= rx_s2_q ^ (^rx_sh_q) ^ par_odd;
            end
        end
    end

    always_comb begin
        spo = '0;
        unique case (a)
            3'd0: if (rx_cnt_q != '0) spo[31:24] = 8'(rx_mem[rx_rp_q]);
            3'd1: spo[31:24] = {err_q, tx_idle, (tx_cnt_q == '0), tx_full, (rx_cnt_q != '0)};
            3'd2: spo[28:24] = ctrl_q;
            3'd3: spo[15:0]  = div_q;
            3'd4: spo[31:16] = {8'(rx_cnt_q), 8'(tx_cnt_q)};
            default: spo = '0;
        endcase
    end

    logic unused_d;
    assign unused_d = ^d[23:16];

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: random bytes through TX, loopback and a bench-driven RX line,
// checked against queue FIFOs and a bit-list frame model.
module tb_uart_fifo;
    localparam int Depth = 16;
    localparam int Bit   = 64;  // clk per bit with DIV=3

    logic        clk, rst_n, we, re, irq, tx, rx_drv, loop, rx_w;
    logic [2:0]  a;
    logic [31:0] d, spo;
    int          n_checks, n_errors;
    bit          fbits[$];

    assign rx_w = loop ? tx : rx_drv;

    uart_fifo dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .d    (d),
        .we   (we),
        .re   (re),
        .spo  (spo),
        .irq  (irq),
        .rx   (rx_w),
        .tx   (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Serial frame as the line should carry it: start, data LSB first, optional parity, stop.
    function automatic void add_frame(input logic [7:0] b, input logic [1:0] par);
        fbits.push_back(1'b0);
        for (int i = 0; i < 8; i++) fbits.push_back(b[i]);
        if (par == 2'b01) fbits.push_back(^b);
        else if (par == 2'b10) fbits.push_back(~^b);
        fbits.push_back(1'b1);
    endfunction

    task automatic wr(input logic [2:0] ad, input logic [31:0] dat);
        @(negedge clk);
        a = ad; d = dat; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] ad, output logic [31:0] v);
        a = ad;
        #1 v = spo;
    endtask

    task automatic pop();
        @(negedge clk);
        a = 3'd0; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic tx_capture(input string tag);
        int t;
        t = 0;
        while (tx !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_start"}, 32'(t < 3000), 32'd1);
        repeat (Bit / 2) @(negedge clk);
        for (int i = 0; i < fbits.size(); i++) begin
            check($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(fbits[i]));
            if (i != fbits.size() - 1) repeat (Bit) @(negedge clk);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic [1:0] par, input bit bad_par,
                           input bit stop);
        bit bits[$];
        fbits.delete();
        add_frame(b, par);
        bits = fbits;
        if (bad_par) bits[9] = !bits[9];
        bits[bits.size() - 1] = stop;
        foreach (bits[i]) begin
            rx_drv = bits[i];
            repeat (Bit) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic wait_rx_level(input int n, input string tag);
        int t;
        logic [31:0] v;
        t = 0;
        do begin
            @(negedge clk);
            rd(3'd4, v);
            t++;
        end while (v[31:24] != 8'(n) && t < 6000);
        check(tag, 32'(v[31:24]), 32'(n));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b, q[$];
        logic [1:0]  pm;
        int          t;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; we = 1'b0; re = 1'b0; a = '0; d = '0; rx_drv = 1'b1; loop = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        rd(3'd1, v); check("rst_status", v, 32'h0C00_0000);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        rd(3'd3, v); check("rst_div", v, 32'd32);
        rd(3'd4, v); check("rst_levels", v, 32'd0);

        // Fixed two-frame waveform, then random bytes with random parity mode
        wr(3'd3, 32'd3);
        fbits.delete(); add_frame(8'h55, 2'b00); add_frame(8'hA3, 2'b00);
        wr(3'd0, 32'h5500_0000);
        wr(3'd0, 32'hA300_0000);
        tx_capture("tx2");
        repeat (40) @(negedge clk);
        rd(3'd1, v); check("tx_idle", 32'(v[27]), 32'd1);

        pm = 2'($urandom_range(0, 3));
        wr(3'd2, {6'b0, pm, 24'b0});
        fbits.delete();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            add_frame(b, pm);
            wr(3'd0, {b, 24'b0});
        end
        tx_capture("txr");
        repeat (40) @(negedge clk);

        // Loopback, even parity, rx interrupt
        wr(3'd2, 32'h0500_0000);
        loop = 1'b1;
        wr(3'd0, 32'h0700_0000);
        wait_rx_level(1, "lb_level");
        repeat (2) @(negedge clk);
        rd(3'd0, v); check("lb_head", v, 32'h0700_0000);
        rd(3'd1, v); check("lb_perr", 32'(v[29]), 32'd0);
        check("lb_irq", 32'(irq), 32'd1);
        pop();
        rd(3'd1, v); check("lb_nonempty", 32'(v[24]), 32'd0);
        check("lb_irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        check("lb_irq_drop", 32'(irq), 32'd0);

        pm = 2'($urandom_range(0, 3));
        wr(3'd2, {6'b0, pm, 24'b0});
        q.delete();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            wr(3'd0, {b, 24'b0});
        end
        wait_rx_level(3, "lbr_level");
        foreach (q[i]) begin
            rd(3'd0, v); check($sformatf("lbr_data%0d", i), v, {q[i], 24'b0});
            pop();
        end
        rd(3'd1, v); check("lbr_errs", 32'(v[31:28]), 32'd0);
        repeat (Bit) @(negedge clk);
        loop = 1'b0;

        // Parity then framing error, W1C
        wr(3'd2, 32'h0200_0000);
        send_rx(8'h3C, 2'b10, 1'b1, 1'b1);
        rd(3'd1, v); check("perr", 32'(v[31:28]), 32'b0010);
        send_rx(8'hC5, 2'b10, 1'b0, 1'b0);
        repeat (2 * Bit) @(negedge clk);
        rd(3'd1, v); check("ferr", 32'(v[31:28]), 32'b0110);
        wr(3'd1, 32'h6000_0000);
        rd(3'd1, v); check("w1c", 32'(v[31:28]), 32'd0);
        rd(3'd0, v); check("err_data0", v, 32'h3C00_0000);
        pop();
        rd(3'd0, v); check("err_data1", v, 32'hC500_0000);
        pop();
        rd(3'd4, v); check("err_level", v, 32'd0);

        // RX overflow, then pop coincident with a push at full
        wr(3'd2, 32'd0);
        q.delete();
        for (int i = 0; i < Depth + 1; i++) begin
            b = 8'($urandom);
            send_rx(b, 2'b00, 1'b0, 1'b1);
            if (q.size() < Depth) q.push_back(b);
        end
        rd(3'd4, v); check("ovr_level", v, 32'h1000_0000);
        rd(3'd1, v); check("ovr_flags", 32'(v[31:28]), 32'b0001);
        rd(3'd0, v); check("ovr_head", v, {q[0], 24'b0});
        wr(3'd1, 32'h1000_0000);
        rd(3'd1, v); check("ovr_clear", 32'(v[28]), 32'd0);
        b = 8'($urandom);
        fork
            send_rx(b, 2'b00, 1'b0, 1'b1);
            begin
                t = 0;
                while (dut.rx_push !== 1'b1 && t < 20 * Bit) begin
                    @(negedge clk);
                    t++;
                end
                check("coinc_seen", 32'(t < 20 * Bit), 32'd1);
                a = 3'd0; re = 1'b1;
                @(negedge clk);
                re = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(b);
        rd(3'd4, v); check("coinc_level", v, 32'h1000_0000);
        rd(3'd1, v); check("coinc_ovr", 32'(v[28]), 32'd0);
        foreach (q[i]) begin
            rd(3'd0, v); check($sformatf("drain%0d", i), v, {q[i], 24'b0});
            pop();
        end

        // Short low glitch must not start a character
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (12) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * Bit) @(negedge clk);
        rd(3'd4, v); check("glitch_level", v, 32'd0);

        // Overfill TX, then reset in the middle of a frame
        for (int i = 0; i < Depth + 2; i++) wr(3'd0, {8'($urandom), 24'b0});
        rd(3'd4, v); check("txf_level", 32'(v[23:16]), 32'd16);
        rd(3'd1, v); check("txf_flags", 32'({v[31], v[25]}), 32'b11);
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1 check("rst_mid_tx", 32'(tx), 32'd1);
        rd(3'd4, v); check("rst_mid_levels", v, 32'd0);
        rd(3'd1, v); check("rst_mid_status", v, 32'h0C00_0000);
        check("rst_mid_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_rst_tx", 32'(tx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Parametrised UART peripheral succeeding the single-byte pComputer UART. It adds TX/RX FIFOs, a runtime-programmable baud divisor, selectable data width and parity, error flags, and a maskable level interrupt. It sits on the CPU MMIO bus with the same a/d/we/spo word interface, byte lane d[31:24]. Software addresses are register index ×4.

Parameters:
CLOCK_FREQ, 62500000, input clock frequency in Hz
BAUD_RATE, 115200, reset baud rate; sets the reset value of DIV
DATA_BITS, 8, character width, legal range 5..8
TX_DEPTH, 16, TX FIFO entries; power of two, ≥2
RX_DEPTH, 16, RX FIFO entries; power of two, ≥2

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
a  in  3  register index
d  in  32  write data; byte payload in d[31:24]
we  in  1  write strobe, one cycle per access
re  in  1  read strobe; pops RX FIFO when a==0
spo  out  32  combinational read data; payload in [31:24], other bits 0
irq  out  1  registered level interrupt
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output, idle high

Behaviour:
- Reset (rst_n=0, async): tx=1, irq=0, both FIFOs empty, all error flags 0, CTRL=0, DIV=CLOCK_FREQ/(BAUD_RATE*16)-1, both FSMs idle. Reset mid-frame aborts the frame; tx goes high immediately.
- Register map:
  - a=0: write pushes d[24+:DATA_BITS] to the TX FIFO. If the FIFO is full, the write is dropped and tx_ovf is set. Read returns the RX FIFO head, or 0 when empty. re pops only when the FIFO is non-empty.
  - a=1 STATUS, read: bit24 rx_nonempty, 25 tx_full, 26 tx_empty, 27 tx_idle (FIFO empty and FSM IDLE), 28 rx_ovr, 29 parity_err, 30 frame_err, 31 tx_ovf. Write: W1C on bits 28..31.
  - a=2 CTRL, R/W: [25:24] parity (00 none, 01 even, 10 odd, 11 none), 26 rx_ie, 27 tx_ie, 28 err_ie.
  - a=3 DIV, R/W: d[15:0]. A write reloads the tick counter.
  - a=4: read returns {rx_level, tx_level}, each 8 bits, in [31:16].
  - Other indices read 0; writes to them are ignored.
- Tick generation: a 16-bit counter counts 0..DIV and emits a one-cycle os_tick on wrap, giving 16× oversampling. TX bit time is 16 os_ticks.
- TX FSM, states IDLE→START→DATA→PARITY→STOP→IDLE:
  - IDLE: when the FIFO is non-empty, pop into the shift register.
  - Each state holds for 16 os_ticks. Data is sent LSB first, DATA_BITS bits.
  - PARITY is skipped when parity is none.
  - STOP is one bit of 1. With a non-empty FIFO, back-to-back frames have no idle gap.
- RX path: rx passes through a 2-flop synchroniser, reset value 1. RX FSM states IDLE→START→DATA→PARITY→STOP:
  - IDLE: a 0 on the synchronised rx starts sampling.
  - START: at sample 8 rx must still be 0, otherwise return to IDLE (glitch reject).
  - DATA and PARITY: sampled at sample 8 of each bit.
  - STOP: sampled at sample 8. If 0, set frame_err. The frame then ends without waiting for sample 15, for early resync.
  - Parity mismatch sets parity_err. The character is pushed to the RX FIFO regardless of errors.
  - Push into a full RX FIFO drops the new byte, keeps the FIFO unchanged, and sets rx_ovr.
- FIFOs:
  - Simultaneous push and pop in the same cycle are both honoured; the level is unchanged. This holds even at full for RX (pop frees the slot) and at empty for TX (no pop occurs, so push only).
  - Pointers wrap modulo depth. Level counters are log2(depth)+1 bits wide.
- Simultaneous W1C and a hardware set of the same error flag: the set wins.
- irq is registered, one cycle after its cause: irq <= (rx_ie & rx_nonempty) | (tx_ie & tx_idle) | (err_ie & any error flag).

Test Plan:
- After reset, read STATUS: value 0x0C000000 (tx_empty, tx_idle). tx=1. irq=0.
- Set DIV=3 and write 0x55, 0xA3 back-to-back. Expected tx waveform: 0,1,0,1,0,1,0,1,0,1,0,1,1,0,0,0,1,0,1,1 at 64 clk/bit, with no gap between frames. tx_idle asserts after the final stop bit.
- Set CTRL parity=even, rx_ie=1. Loop tx to rx and send 0x07. Expected: RX head reads 0x07, parity_err=0, irq=1. Pop with re → rx_nonempty=0 and irq deasserts one cycle later.
- Drive a frame with odd parity bit wrong, then a frame with stop=0. Expected: parity_err then frame_err set; W1C of 0x60000000 clears both.
- Receive RX_DEPTH+1 bytes without popping. Expected: rx_level=16, rx_ovr=1, and the first 16 bytes are read back in order. Then pop coincident with a push at full: level stays 16 and rx_ovr is not re-set.
- A 3-os_tick low glitch on rx produces no push. Assert rst_n low mid-TX-frame: tx=1 immediately and FIFOs are empty.
